// File: rtl/writeback_stage.sv
// Registered writeback: selects ALU/load/PC+4/CSR result, 1-cycle latency after completion; in_ready=0 while a load is outstanding.
// Optional WB_LOAD_ALIGN_EN enables the funct3/addr_lo load formatter; otherwise load data passes through unchanged.
module writeback_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_reg_wr,
    input  logic [RA_W-1:0] in_rd,
    input  logic [1:0]      in_wb_sel,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_csr_rdata,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic            flush,
    output logic            rf_we,
    output logic [RA_W-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [XLEN-1:0] retire_count,
    output logic            rsp_err
);

    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    state_t            state_q, state_d;
    logic [RA_W-1:0]   rd_q, rd_d;
    logic              reg_wr_q, reg_wr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic              rf_we_q, rf_we_d;
    logic [RA_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic [XLEN-1:0]   retire_q, retire_d;
    logic              rsp_err_q, rsp_err_d;

    logic              accept;
    logic              is_load;
    logic              cmp_vld;
    logic [RA_W-1:0]   cmp_rd;
    logic              cmp_wr;
    logic [XLEN-1:0]   cmp_data;
    logic [XLEN-1:0]   src_data;
    logic [XLEN-1:0]   load_now;
    logic [XLEN-1:0]   load_held;

`ifdef WB_LOAD_ALIGN_EN
    function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] d,
                                                 input logic [2:0]      f3,
                                                 input logic [1:0]      lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(d >> {lo, 3'b000});
        h = 16'(d >> {lo[1], 4'b0000});
        case (f3)
            3'b000:  fmt_load = {{(XLEN-8){b[7]}}, b};
            3'b100:  fmt_load = {{(XLEN-8){1'b0}}, b};
            3'b001:  fmt_load = {{(XLEN-16){h[15]}}, h};
            3'b101:  fmt_load = {{(XLEN-16){1'b0}}, h};
            default: fmt_load = d;
        endcase
    endfunction

    assign load_now  = fmt_load(mem_rsp_data, in_funct3, in_addr_lo);
    assign load_held = fmt_load(mem_rsp_data, funct3_q, addr_lo_q);
`else
    logic unused_fmt;
    assign load_now   = mem_rsp_data;
    assign load_held  = mem_rsp_data;
    assign unused_fmt = ^{in_funct3, in_addr_lo, funct3_q, addr_lo_q};
`endif

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign is_load  = (in_wb_sel == 2'b01);

    always_comb begin
        src_data = in_alu_result;
        case (in_wb_sel)
            2'b00:   src_data = in_alu_result;
            2'b01:   src_data = load_now;
            2'b10:   src_data = in_pc + XLEN'(4);
            default: src_data = in_csr_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        reg_wr_d   = reg_wr_q;
        funct3_d   = funct3_q;
        addr_lo_d  = addr_lo_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        retire_d   = retire_q;
        rsp_err_d  = rsp_err_q;
        cmp_vld    = 1'b0;
        cmp_rd     = in_rd;
        cmp_wr     = in_reg_wr;
        cmp_data   = src_data;

        case (state_q)
            IDLE: begin
                if (accept && !flush) begin
                    if (!is_load || mem_rsp_valid) begin
                        cmp_vld = 1'b1;
                    end else begin
                        rd_d      = in_rd;
                        reg_wr_d  = in_reg_wr;
                        funct3_d  = in_funct3;
                        addr_lo_d = in_addr_lo;
                        state_d   = WAIT_LOAD;
                    end
                end
                // A response with no load to consume is a protocol error, not data.
                if (mem_rsp_valid && !(accept && is_load) && !flush) begin
                    rsp_err_d = 1'b1;
                end
            end
            WAIT_LOAD: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (mem_rsp_valid) begin
                    cmp_vld  = 1'b1;
                    cmp_rd   = rd_q;
                    cmp_wr   = reg_wr_q;
                    cmp_data = load_held;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cmp_vld) begin
            retire_d = retire_q + XLEN'(1);
            if (cmp_wr && (cmp_rd != '0)) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = cmp_rd;
                rf_wdata_d = cmp_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            reg_wr_q   <= 1'b0;
            funct3_q   <= '0;
            addr_lo_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            retire_q   <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            reg_wr_q   <= reg_wr_d;
            funct3_q   <= funct3_d;
            addr_lo_q  <= addr_lo_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            retire_q   <= retire_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign retire_count = retire_q;
    assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus random traffic against a transaction-level reference model.
module tb_writeback_stage;

`ifdef WB_LOAD_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, in_reg_wr;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result, in_pc, in_csr_rdata;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        flush;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, retire_count;
    logic        rsp_err;

    always #5 clk = ~clk;

    writeback_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg_wr(in_reg_wr),
        .in_rd(in_rd), .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result),
        .in_pc(in_pc), .in_csr_rdata(in_csr_rdata), .in_funct3(in_funct3),
        .in_addr_lo(in_addr_lo), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .flush(flush), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .retire_count(retire_count),
        .rsp_err(rsp_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference model: outstanding loads kept as a queue of transactions.
    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic [2:0] f3;
        logic [1:0] lo;
    } pend_t;

    pend_t       pend_q[$];
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata, m_count;
    logic        m_err;

    function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [2:0] f3,
                                             input logic [1:0] lo);
        longint unsigned bytev, half;
        if (!ALIGN) return d;
        bytev = (longint'(d) >> (8 * int'(lo))) % 256;
        half  = (longint'(d) >> (16 * int'(lo[1]))) % 65536;
        case (f3)
            3'd0: return 32'((bytev >= 128) ? bytev + 64'hFFFF_FF00 : bytev);
            3'd4: return 32'(bytev);
            3'd1: return 32'((half >= 32768) ? half + 64'hFFFF_0000 : half);
            3'd5: return 32'(half);
            default: return d;
        endcase
    endfunction

    task automatic model_complete(input logic [4:0] rd, input logic wr, input logic [31:0] data);
        m_count = m_count + 1;
        if (wr && rd != 0) begin
            m_we    = 1'b1;
            m_waddr = rd;
            m_wdata = data;
        end
    endtask

    task automatic clr();
        in_valid = 0; in_reg_wr = 0; in_rd = 0; in_wb_sel = 0;
        in_alu_result = 0; in_pc = 0; in_csr_rdata = 0; in_funct3 = 0;
        in_addr_lo = 0; mem_rsp_valid = 0; mem_rsp_data = 0; flush = 0;
    endtask

    task automatic step(input string tag);
        pend_t p;
        logic [31:0] src;
        check({tag, ".rdy"}, {31'b0, in_ready}, {31'b0, pend_q.size() == 0});
        m_we = 1'b0;
        if (pend_q.size() == 0) begin
            if (in_valid && !flush) begin
                case (in_wb_sel)
                    2'd0:    src = in_alu_result;
                    2'd2:    src = in_pc + 32'd4;
                    default: src = in_csr_rdata;
                endcase
                if (in_wb_sel != 2'd1) model_complete(in_rd, in_reg_wr, src);
                else if (mem_rsp_valid)
                    model_complete(in_rd, in_reg_wr, ref_load(mem_rsp_data, in_funct3, in_addr_lo));
                else begin
                    p.rd = in_rd; p.wr = in_reg_wr; p.f3 = in_funct3; p.lo = in_addr_lo;
                    pend_q.push_back(p);
                end
            end
            if (mem_rsp_valid && !flush && !(in_valid && in_wb_sel == 2'd1)) m_err = 1'b1;
        end else begin
            if (flush) pend_q.delete();
            else if (mem_rsp_valid) begin
                p = pend_q.pop_front();
                model_complete(p.rd, p.wr, ref_load(mem_rsp_data, p.f3, p.lo));
            end
        end
        @(posedge clk);
        #1;
        check({tag, ".we"},  {31'b0, rf_we}, {31'b0, m_we});
        check({tag, ".wa"},  {27'b0, rf_waddr}, {27'b0, m_waddr});
        check({tag, ".wd"},  rf_wdata, m_wdata);
        check({tag, ".cnt"}, retire_count, m_count);
        check({tag, ".err"}, {31'b0, rsp_err}, {31'b0, m_err});
    endtask

    task automatic do_reset(input string tag);
        clr();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        pend_q.delete();
        m_we = 0; m_waddr = 0; m_wdata = 0; m_count = 0; m_err = 0;
        check({tag, ".we"},  {31'b0, rf_we}, 32'd0);
        check({tag, ".wa"},  {27'b0, rf_waddr}, 32'd0);
        check({tag, ".wd"},  rf_wdata, 32'd0);
        check({tag, ".cnt"}, retire_count, 32'd0);
        check({tag, ".err"}, {31'b0, rsp_err}, 32'd0);
        check({tag, ".rdy"}, {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
    endtask

    initial begin
        clr();
        do_reset("rst");

        // Back-to-back non-load sources.
        in_valid = 1; in_reg_wr = 1; in_rd = 5; in_wb_sel = 2'd0; in_alu_result = 32'h1234;
        step("alu");
        check("alu.val", rf_wdata, 32'h0000_1234);
        in_rd = 1; in_wb_sel = 2'd2; in_pc = 32'hFFFF_FFFC;
        step("pc4");
        check("pc4.we", {31'b0, rf_we}, 32'd1);
        check("pc4.val", rf_wdata, 32'h0000_0000);
        check("pc4.cnt", retire_count, 32'd2);

        // Delayed signed-byte load.
        clr();
        in_valid = 1; in_reg_wr = 1; in_rd = 7; in_wb_sel = 2'd1; in_funct3 = 3'd0; in_addr_lo = 2'd2;
        step("ld.acc");
        clr();
        step("ld.w1");
        step("ld.w2");
        mem_rsp_valid = 1; mem_rsp_data = 32'h0080_0000;
        step("ld.rsp");
        check("ld.val", rf_wdata, ALIGN ? 32'hFFFF_FF80 : 32'h0080_0000);
        check("ld.addr", {27'b0, rf_waddr}, 32'd7);
        clr();
        step("ld.post");

        // Flush while a load is pending, with a same-cycle response.
        in_valid = 1; in_reg_wr = 1; in_rd = 9; in_wb_sel = 2'd1;
        step("fl.acc");
        clr();
        flush = 1; mem_rsp_valid = 1; mem_rsp_data = 32'hCAFE_F00D;
        step("fl.kill");
        check("fl.we", {31'b0, rf_we}, 32'd0);
        check("fl.cnt", retire_count, 32'd3);
        clr();
        step("fl.idle");

        // CSR to x0 retires without a write; then an unexpected response.
        in_valid = 1; in_reg_wr = 1; in_rd = 0; in_wb_sel = 2'd3; in_csr_rdata = 32'hDEAD_BEEF;
        step("csr0");
        check("csr0.we", {31'b0, rf_we}, 32'd0);
        check("csr0.cnt", retire_count, 32'd4);
        clr();
        mem_rsp_valid = 1;
        step("unexp");
        check("unexp.err", {31'b0, rsp_err}, 32'd1);
        clr();
        step("sticky1");
        step("sticky2");
        check("sticky.err", {31'b0, rsp_err}, 32'd1);

        // Reset while a load is held discards it.
        in_valid = 1; in_reg_wr = 1; in_rd = 12; in_wb_sel = 2'd1;
        step("rl.acc");
        do_reset("rl.rst");
        step("rl.idle");

        // Counter wrap.
        force dut.retire_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        m_count = 32'hFFFF_FFFF;
        in_valid = 1; in_reg_wr = 1; in_rd = 3; in_wb_sel = 2'd0; in_alu_result = 32'h5;
        step("wrap");
        check("wrap.cnt", retire_count, 32'd0);

        // Random traffic.
        do_reset("rrst");
        for (int i = 0; i < 400; i++) begin
            clr();
            in_valid      = ($urandom_range(0, 3) != 0);
            in_reg_wr     = ($urandom_range(0, 3) != 0);
            in_rd         = 5'($urandom_range(0, 31));
            in_wb_sel     = 2'($urandom_range(0, 3));
            in_alu_result = $urandom;
            in_pc         = $urandom;
            in_csr_rdata  = $urandom;
            in_funct3     = 3'($urandom_range(0, 7));
            in_addr_lo    = 2'($urandom_range(0, 3));
            mem_rsp_data  = $urandom;
            flush         = ($urandom_range(0, 15) == 0);
            if (pend_q.size() != 0)
                mem_rsp_valid = ($urandom_range(0, 2) == 0);
            else if (in_valid && in_wb_sel == 2'd1)
                mem_rsp_valid = ($urandom_range(0, 1) == 0);
            else
                mem_rsp_valid = !flush && ($urandom_range(0, 99) == 0);
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
